// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller family.
// Holds the fade FSM state encoding used by the controller and its bench.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        BRTH_DN = 2'd2,
        BRTH_UP = 2'd3
    } fade_state_t;

endpackage

// File: rtl/pwm_period_tracker.sv
// Counts step pulses modulo 2^N and flags the step that wraps the count,
// which marks the start of a new PWM period.
module pwm_period_tracker #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic step,
    output logic boundary
);

    logic [N-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (ena && step) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the controller acts on the same edge that wraps the count.
    assign boundary = ena && step && (count == {N{1'b1}});

endmodule

// File: rtl/pwm_fade_controller.sv
// Moves the PWM duty one LSB at a time toward a loaded target, once per
// rate_q period boundaries, with an optional continuous triangle "breathe" mode.
module pwm_fade_controller
    import pwm_pkg::*;
#(
    parameter int N      = 4,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              step,
    input  logic [N-1:0]      target,
    input  logic [RATE_W-1:0] rate,
    input  logic              load,
    input  logic              breathe,
    output logic [N-1:0]      duty,
    output logic              busy,
    output logic              done
);

    fade_state_t       state, state_n;
    logic [N-1:0]      target_q, target_n, goal, duty_n;
    logic [RATE_W-1:0] rate_q, rate_n, rate_cnt, rate_cnt_n;
    logic              boundary, rate_wrap, move, done_n;

    pwm_period_tracker #(.N(N)) u_period (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .step     (step),
        .boundary (boundary)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        target_n   = load ? target : target_q;
        rate_n     = rate_q;
        if (load) begin
            rate_n = (rate == '0) ? RATE_W'(1) : rate;
        end

        goal      = (state == BRTH_DN) ? '0 : target_q;
        rate_wrap = (rate_cnt == rate_q - 1'b1);
        // A load in the same cycle as a boundary wins: no duty step that cycle.
        move      = boundary && !load && (state != IDLE) && rate_wrap;

        rate_cnt_n = rate_cnt;
        if (load || state == IDLE) begin
            rate_cnt_n = '0;
        end else if (boundary) begin
            rate_cnt_n = rate_wrap ? '0 : rate_cnt + 1'b1;
        end

        duty_n = duty;
        if (move && duty < goal) begin
            duty_n = duty + 1'b1;
        end else if (move && duty > goal) begin
            duty_n = duty - 1'b1;
        end

        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    if (target != duty) begin
                        state_n = RAMP;
                    end else begin
                        done_n = 1'b1;
                    end
                end else if (breathe && target_q != '0) begin
                    state_n = BRTH_DN;
                end
            end
            RAMP: begin
                if (duty_n == target_n) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            BRTH_DN: begin
                if (!breathe) begin
                    state_n = RAMP;
                end else if (duty_n == '0) begin
                    // A zero target leaves nothing to breathe toward.
                    state_n = (target_n == '0) ? IDLE : BRTH_UP;
                end
            end
            BRTH_UP: begin
                if (!breathe) begin
                    state_n = RAMP;
                end else if (duty_n == target_n) begin
                    state_n = BRTH_DN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            target_q <= '0;
            rate_q   <= RATE_W'(1);
            rate_cnt <= '0;
            done     <= 1'b0;
        end else if (ena) begin
            state    <= state_n;
            duty     <= duty_n;
            target_q <= target_n;
            rate_q   <= rate_n;
            rate_cnt <= rate_cnt_n;
            done     <= done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller (N=4): ramps, rate handling, retargeting,
// breathe mode, enable freeze and asynchronous reset, with hand-computed expectations.
module tb_pwm_fade_controller;

    localparam int N      = 4;
    localparam int RATE_W = 8;

    logic              clk;
    logic              rst;
    logic              ena;
    logic              step;
    logic [N-1:0]      target;
    logic [RATE_W-1:0] rate;
    logic              load;
    logic              breathe;
    logic [N-1:0]      duty;
    logic              busy;
    logic              done;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int sc        = 0;   // step pulses the DUT has accepted since reset
    int d0        = 0;

    int exp_breathe [8] = '{2, 1, 0, 1, 2, 3, 2, 1};

    pwm_fade_controller #(.N(N), .RATE_W(RATE_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .step    (step),
        .target  (target),
        .rate    (rate),
        .load    (load),
        .breathe (breathe),
        .duty    (duty),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
            sc++;
        end
    endtask

    task automatic to_boundary();
        steps(16 - (sc % 16));
    endtask

    task automatic do_load(input logic [N-1:0] t, input logic [RATE_W-1:0] r);
        target = t;
        rate   = r;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic load_on_boundary(input logic [N-1:0] t, input logic [RATE_W-1:0] r);
        target = t;
        rate   = r;
        load   = 1'b1;
        step   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        step   = 1'b0;
        @(negedge clk);
        sc++;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; step = 1'b0; target = '0; rate = '0;
        load = 1'b0; breathe = 1'b0;
        #1;
        check("reset_duty", 32'(duty), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp 0 -> 8 at rate 1: one LSB every 16 steps, no early change.
        d0 = done_seen;
        do_load(4'd8, 8'd1);
        check("ramp8_busy_start", 32'(busy), 1);
        for (int k = 1; k <= 8; k++) begin
            steps(15);
            check("ramp8_hold", 32'(duty), 32'(k - 1));
            check("ramp8_no_done", 32'(done_seen), 32'(d0));
            steps(1);
            check("ramp8_step", 32'(duty), 32'(k));
            check("ramp8_busy", 32'(busy), (k < 8) ? 1 : 0);
        end
        idle(2);
        check("ramp8_done_once", 32'(done_seen), 32'(d0 + 1));
        check("ramp8_done_low", 32'(done), 0);

        // Rate 0 behaves as rate 1: 8 -> 4.
        d0 = done_seen;
        do_load(4'd4, 8'd0);
        for (int k = 7; k >= 4; k--) begin
            to_boundary();
            check("rate0_step", 32'(duty), 32'(k));
        end
        idle(2);
        check("rate0_done", 32'(done_seen), 32'(d0 + 1));

        // Load equal to current duty: stays idle, single done.
        d0 = done_seen;
        do_load(4'd4, 8'd3);
        check("same_target_busy", 32'(busy), 0);
        idle(2);
        check("same_target_done", 32'(done_seen), 32'(d0 + 1));

        // Retarget mid-ramp, load colliding with a boundary.
        do_load(4'd15, 8'd1);
        to_boundary();
        check("up_to5", 32'(duty), 5);
        steps(15);
        d0 = done_seen;
        load_on_boundary(4'd2, 8'd1);
        check("load_beats_boundary", 32'(duty), 5);
        check("retarget_busy", 32'(busy), 1);
        to_boundary();
        check("retarget_4", 32'(duty), 4);
        to_boundary();
        check("retarget_3", 32'(duty), 3);
        check("retarget_no_early_done", 32'(done_seen), 32'(d0));
        to_boundary();
        check("retarget_2", 32'(duty), 2);
        idle(2);
        check("retarget_done", 32'(done_seen), 32'(d0 + 1));

        // Rate 3: one LSB every third boundary, 2 -> 4.
        do_load(4'd4, 8'd3);
        to_boundary();
        to_boundary();
        check("rate3_hold2", 32'(duty), 2);
        to_boundary();
        check("rate3_first", 32'(duty), 3);
        to_boundary();
        to_boundary();
        check("rate3_hold5", 32'(duty), 3);
        to_boundary();
        check("rate3_second", 32'(duty), 4);
        check("rate3_idle", 32'(busy), 0);

        // Breathe between 0 and 3, then release at duty 1.
        do_load(4'd3, 8'd1);
        to_boundary();
        check("pre_breathe_duty", 32'(duty), 3);
        idle(2);
        d0 = done_seen;
        breathe = 1'b1;
        idle(1);
        check("breathe_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            to_boundary();
            check("breathe_duty", 32'(duty), 32'(exp_breathe[i]));
        end
        check("breathe_no_done", 32'(done_seen), 32'(d0));
        breathe = 1'b0;
        idle(1);
        check("unbreathe_busy", 32'(busy), 1);
        to_boundary();
        check("unbreathe_2", 32'(duty), 2);
        check("unbreathe_no_done", 32'(done_seen), 32'(d0));
        to_boundary();
        check("unbreathe_3", 32'(duty), 3);
        idle(2);
        check("unbreathe_done", 32'(done_seen), 32'(d0 + 1));

        // Enable freeze at duty 6 with five steps into the period.
        do_load(4'd10, 8'd1);
        to_boundary();
        to_boundary();
        to_boundary();
        check("pre_freeze_duty", 32'(duty), 6);
        steps(5);
        ena = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step = 1'b1;
            load = (i == 50);
            target = '0;
            @(negedge clk);
            step = 1'b0;
            load = 1'b0;
            @(negedge clk);
        end
        check("freeze_duty", 32'(duty), 6);
        check("freeze_busy", 32'(busy), 1);
        check("freeze_done", 32'(done), 0);
        ena = 1'b1;
        steps(10);
        check("resume_hold", 32'(duty), 6);
        steps(1);
        check("resume_step", 32'(duty), 7);

        // Asynchronous reset between edges mid-ramp.
        to_boundary();
        check("pre_reset_duty", 32'(duty), 8);
        steps(7);
        d0 = done_seen;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", 32'(duty), 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        sc = 0;
        steps(40);
        check("post_rst_duty", 32'(duty), 0);
        check("post_rst_busy", 32'(busy), 0);
        idle(2);
        check("post_rst_no_done", 32'(done_seen), 32'(d0));

        // Breathe with a zero captured target stays idle.
        breathe = 1'b1;
        steps(20);
        check("breathe_zero_busy", 32'(busy), 0);
        check("breathe_zero_duty", 32'(duty), 0);
        breathe = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
